// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback and
// raises datapath strobes, with a memory-wait watchdog that traps on timeout.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] WaitLast = CW'(TIMEOUT - 1);

    state_e        r_state, w_state_d;
    logic [6:0]    r_op;
    logic [2:0]    r_f3;
    logic [CW-1:0] r_wait, w_wait_d;
    logic [31:0]   r_instret;
    logic          w_retire;
    logic          w_waiting;

    // funct3 is latched for datapath visibility but does not steer any strobe.
    logic w_unused;
    assign w_unused = ^r_f3;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr,
            OpLui, OpAuipc, OpFence, OpSystem: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_state_d = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        case (r_state)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    w_state_d = StDecode;
                end else if (r_wait == WaitLast) begin
                    w_state_d = StTrap;
                end
            end
            StDecode: w_state_d = is_legal(opcode) ? StExec : StTrap;
            StExec: begin
                case (r_op)
                    OpR:                 w_state_d = StWb;
                    OpImm: begin
                        alu_b_sel = 1'b1;
                        w_state_d = StWb;
                    end
                    OpLoad, OpStore: begin
                        alu_b_sel = 1'b1;
                        w_state_d = StMem;
                    end
                    OpBranch: begin
                        pc_we     = branch_taken;
                        pc_sel    = 2'd1;
                        w_state_d = StFetch;
                    end
                    OpJal: begin
                        pc_we     = 1'b1;
                        pc_sel    = 2'd1;
                        w_state_d = StWb;
                    end
                    OpJalr: begin
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = 2'd2;
                        w_state_d = StWb;
                    end
                    OpLui:               w_state_d = StWb;
                    OpAuipc: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        w_state_d = StWb;
                    end
                    OpFence:             w_state_d = StFetch;
                    default:             w_state_d = StTrap;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (r_op == OpStore);
                if (mem_ready) begin
                    w_state_d = (r_op == OpStore) ? StFetch : StWb;
                end else if (r_wait == WaitLast) begin
                    w_state_d = StTrap;
                end
            end
            StWb: begin
                reg_we = 1'b1;
                case (r_op)
                    OpLoad:        wb_sel = 2'd1;
                    OpJal, OpJalr: wb_sel = 2'd2;
                    OpLui:         wb_sel = 2'd3;
                    default:       wb_sel = 2'd0;
                endcase
                w_state_d = StFetch;
            end
            default: w_state_d = StTrap;
        endcase
        // Reset holds the state at FETCH, so strobes must be masked explicitly.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
        end
    end

    assign w_retire  = (w_state_d == StFetch) &&
                       (r_state == StExec || r_state == StMem || r_state == StWb);
    assign w_waiting = (r_state == StFetch || r_state == StMem) && !mem_ready;

    always_comb begin
        w_wait_d = r_wait;
        if (w_state_d != r_state && (w_state_d == StFetch || w_state_d == StMem)) begin
            w_wait_d = '0;
        end else if (w_waiting) begin
            w_wait_d = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StFetch;
            r_wait    <= '0;
            r_op      <= '0;
            r_f3      <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            if (r_state == StDecode) begin
                r_op <= opcode;
                r_f3 <= funct3;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign state   = r_state;
    assign halted  = (r_state == StTrap);
    assign instret = r_instret;

endmodule
